// File: rtl/pattern_serializer_if.sv
// Bundle of pattern-write, frame-control and serial-output signals for pattern_serializer.
// master drives writes/controls and observes the serial stream; slave is the serializer.
interface pattern_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int BW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW-1:0]    last_word;
    logic             mode_loop;
    logic             msb_first;
    logic             stall;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic [BW-1:0]    bit_idx;
    logic [AW-1:0]    word_idx;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, start, last_word, mode_loop, msb_first, stall, abort,
        input  out, out_valid, bit_idx, word_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, last_word, mode_loop, msb_first, stall, abort,
        output out, out_valid, bit_idx, word_idx, busy, done
    );
endinterface

// File: rtl/pattern_serializer.sv
// Pattern RAM serializer: emits stored words one bit per clock, first bit one edge after start is seen.
// stall inserts one out_valid=0 bubble per cycle with all state held; abort returns to IDLE at once.
module pattern_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic clock,
    input  logic clear,
    pattern_serializer_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [BW-1:0]    bit_q, bit_n;
    logic [AW-1:0]    word_q, word_n;
    logic [AW-1:0]    last_q, last_n;
    logic             loop_q, loop_n;
    logic             msb_q, msb_n;
    logic             out_q, out_n;
    logic             vld_q, vld_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] cur_word;
    logic [BW-1:0]    sel;

    // Pattern storage is deliberately left out of reset so patterns survive a clear.
    always_ff @(posedge clock) begin
        if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign cur_word = mem[word_q];
    assign sel      = msb_q ? (BW'(WIDTH - 1) - bit_q) : bit_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            bit_q  <= '0;
            word_q <= '0;
            last_q <= '0;
            loop_q <= 1'b0;
            msb_q  <= 1'b0;
            out_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            bit_q  <= bit_n;
            word_q <= word_n;
            last_q <= last_n;
            loop_q <= loop_n;
            msb_q  <= msb_n;
            out_q  <= out_n;
            vld_q  <= vld_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_q;
        word_n  = word_q;
        last_n  = last_q;
        loop_n  = loop_q;
        msb_n   = msb_q;
        out_n   = out_q;
        vld_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = RUN;
                    last_n  = bus.last_word;
                    loop_n  = bus.mode_loop;
                    msb_n   = bus.msb_first;
                    bit_n   = '0;
                    word_n  = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    bit_n   = '0;
                    word_n  = '0;
                end else if (!bus.stall) begin
                    out_n = cur_word[sel];
                    vld_n = 1'b1;
                    if (bit_q != BW'(WIDTH - 1)) begin
                        bit_n = bit_q + BW'(1);
                    end else if (word_q < last_q) begin
                        bit_n  = '0;
                        word_n = word_q + AW'(1);
                    end else begin
                        // Frame complete: loop mode restarts at word 0 on the very next edge.
                        done_n = 1'b1;
                        bit_n  = '0;
                        word_n = '0;
                        if (!loop_q)
                            state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.done      = done_q;
    assign bus.bit_idx   = bit_q;
    assign bus.word_idx  = word_q;
    assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: bit streams, stall, abort, clear, busy restart and full depth.
module tb_pattern_serializer;
    logic clock;
    logic clear;
    int   checks;
    int   failures;

    pattern_serializer_if #(.WIDTH(8), .DEPTH(16)) bus ();

    pattern_serializer #(.WIDTH(8), .DEPTH(16)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] lw, input logic lp, input logic msb);
        bus.last_word = lw;
        bus.mode_loop = lp;
        bus.msb_first = msb;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_vld", bus.out_valid, 0);
    endtask

    // seq[n-1] is the first expected bit; dmask marks where done must pulse.
    task automatic expect_bits(input string tag, input int n, input logic [31:0] seq,
                               input logic [31:0] dmask);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_vld%0d", tag, i), bus.out_valid, 1);
            chk($sformatf("%s_bit%0d", tag, i), bus.out, seq[n-1-i]);
            chk($sformatf("%s_done%0d", tag, i), bus.done, dmask[n-1-i]);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        clear         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.last_word = '0;
        bus.mode_loop = 1'b0;
        bus.msb_first = 1'b0;
        bus.stall     = 1'b0;
        bus.abort     = 1'b0;
        #12;
        chk("rst_out", bus.out, 0);
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bit", bus.bit_idx, 0);
        chk("rst_word", bus.word_idx, 0);
        clear = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);

        wr(4'd0, 8'hAA);
        wr(4'd1, 8'hCC);
        for (int a = 2; a < 15; a++) wr(4'(a), 8'h3C);
        wr(4'd15, 8'hFF);

        // One-shot LSB first over two words.
        start_frame(4'd1, 1'b0, 1'b0);
        expect_bits("lsb", 16, 32'h5533, 32'h0001);
        chk("lsb_busy_end", bus.busy, 0);

        // MSB first, with start and a new last_word offered mid-frame.
        start_frame(4'd1, 1'b0, 1'b1);
        expect_bits("msb_a", 3, 32'h5, 32'h0);
        bus.start     = 1'b1;
        bus.last_word = 4'd0;
        expect_bits("msb_b", 1, 32'h0, 32'h0);
        bus.start     = 1'b0;
        expect_bits("msb_c", 12, 32'hACC, 32'h001);
        chk("msb_busy_end", bus.busy, 0);

        // Loop mode, one-word frame, repeats without gaps.
        wr(4'd0, 8'h81);
        start_frame(4'd0, 1'b1, 1'b0);
        expect_bits("loop", 24, 32'h818181, 32'h010101);
        chk("loop_busy", bus.busy, 1);
        bus.abort = 1'b1;
        bus.stall = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        chk("loop_abt_busy", bus.busy, 0);
        chk("loop_abt_vld", bus.out_valid, 0);
        chk("loop_abt_done", bus.done, 0);
        chk("loop_abt_bit", bus.bit_idx, 0);

        // Stall for three cycles after the fourth bit.
        wr(4'd0, 8'hAA);
        start_frame(4'd0, 1'b0, 1'b0);
        expect_bits("stl_a", 4, 32'h5, 32'h0);
        bus.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stl_vld%0d", s), bus.out_valid, 0);
            chk($sformatf("stl_done%0d", s), bus.done, 0);
            chk($sformatf("stl_bit_idx%0d", s), bus.bit_idx, 4);
            chk($sformatf("stl_out%0d", s), bus.out, 1);
        end
        bus.stall = 1'b0;
        expect_bits("stl_b", 4, 32'h5, 32'h1);
        chk("stl_busy_end", bus.busy, 0);

        // Abort after the fifth bit.
        start_frame(4'd0, 1'b0, 1'b0);
        expect_bits("abt_a", 5, 32'h0A, 32'h0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abt_busy", bus.busy, 0);
        chk("abt_vld", bus.out_valid, 0);
        chk("abt_done", bus.done, 0);
        chk("abt_bit", bus.bit_idx, 0);
        chk("abt_word", bus.word_idx, 0);
        chk("abt_out_hold", bus.out, 0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abt_blocks_start", bus.busy, 0);

        // Clear pulsed between edges mid-frame.
        start_frame(4'd0, 1'b0, 1'b0);
        expect_bits("clr_a", 4, 32'h5, 32'h0);
        #2 clear = 1'b1;
        #1;
        chk("clr_out", bus.out, 0);
        chk("clr_vld", bus.out_valid, 0);
        chk("clr_busy", bus.busy, 0);
        chk("clr_bit", bus.bit_idx, 0);
        chk("clr_word", bus.word_idx, 0);
        chk("clr_done", bus.done, 0);
        clear = 1'b0;
        tick();
        chk("clr_idle", bus.busy, 0);
        start_frame(4'd0, 1'b0, 1'b0);
        expect_bits("clr_mem", 8, 32'h55, 32'h01);

        // Full-depth frame; last word is all ones.
        start_frame(4'd15, 1'b0, 1'b0);
        for (int b = 0; b < 120; b++) begin
            tick();
            chk($sformatf("deep_vld%0d", b), bus.out_valid, 1);
            chk($sformatf("deep_done%0d", b), bus.done, 0);
        end
        chk("deep_word15", bus.word_idx, 15);
        chk("deep_bit0", bus.bit_idx, 0);
        expect_bits("deep", 8, 32'hFF, 32'h01);
        chk("deep_word_wrap", bus.word_idx, 0);
        chk("deep_busy_end", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parametrised pattern-memory serializer: a small write-port pattern RAM feeds a bit counter, a word counter and a bit-select mux. The block emits stored words one bit per clock on a single serial line. It generalises the fixed 8-bit, counter-plus-mux pattern generator with configurable width and depth, a programmable frame length, bit order, one-shot or loop mode, stall and abort. It sits between the control logic that loads patterns and any single-bit consumer, such as test stimulus or line drivers.

## Interface
- WIDTH, 8, bits per pattern word; power of 2, ≥2
- DEPTH, 16, words in pattern memory; power of 2, ≥2
- BW = log2(WIDTH), AW = log2(DEPTH), derived localparams, not overridable

- clock  in  1  sole clock, rising-edge
- clear  in  1  reset, asynchronous, active-high
- wr_en  in  1  write strobe for pattern memory
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- start  in  1  begin a frame (honoured only in IDLE)
- last_word  in  AW  index of final word in frame; latched at start
- mode_loop  in  1  1 = restart frame after last word; latched at start
- msb_first  in  1  1 = bit WIDTH-1 first within each word; latched at start
- stall  in  1  hold serialization this cycle
- abort  in  1  terminate frame, return to IDLE
- out  out  1  serial data bit (registered)
- out_valid  out  1  out carries a new bit this cycle (registered)
- bit_idx  out  BW  bit counter (sequence position, not physical bit)
- word_idx  out  AW  word counter
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on final bit of each frame

## Operation
- Memory: DEPTH×WIDTH register array.
  - Synchronous write on wr_en, accepted in any state.
  - Combinational read at word_idx.
  - Not cleared by clear; contents are undefined until written.
- States: IDLE, RUN.
- IDLE → RUN when start=1 and abort=0.
  - Latch last_word, mode_loop and msb_first.
  - Set bit_idx=0 and word_idx=0.
- Each RUN edge, in priority order:
  - **abort=1:** → IDLE; out_valid←0, done←0; counters←0; out holds.
  - **stall=1:** counters and out hold; out_valid←0, done←0.
  - **Otherwise:** out←mem[word_idx][sel], where sel = msb_first ? WIDTH-1-bit_idx : bit_idx; out_valid←1. Then advance:
    - bit_idx < WIDTH-1: bit_idx+1.
    - bit_idx = WIDTH-1 and word_idx < last_word: bit_idx←0, word_idx+1.
    - bit_idx = WIDTH-1 and word_idx = last_word: done←1, counters←0. If loop mode, stay in RUN; otherwise → IDLE.
- start is ignored while in RUN.
- Inputs other than stall and abort have no effect on a frame in progress.
- last_word=0 gives a one-word frame.
- Frame length is (last_word+1)×WIDTH bits.
- A write to the word currently being read, at the same edge as its read: the old bit is emitted; the new data is used on subsequent reads.

## Timing
- Reset values: out=0, out_valid=0, done=0, busy=0, bit_idx=0, word_idx=0, state=IDLE.
- clear acts immediately, with no clock needed.
- clear asserted mid-frame aborts the frame with no done pulse.
- After clear deasserts, the block waits in IDLE for start.
- Latency:
  - start sampled at edge k → busy=1 after edge k.
  - First out_valid=1 after edge k+1, unless stalled.
- Throughput: 1 bit/clock with stall=0; each stalled cycle inserts exactly one out_valid=0 bubble.
- done is asserted after the same edge as the final bit's out_valid and lasts one cycle.
- One-shot: busy=0 after that same edge, so a new start is accepted on the next edge.
- Loop: the first bit of the next frame follows the last bit with no gap.
- abort and stall together: abort wins.
- abort in IDLE: no effect; it also blocks start in that cycle.

## Test plan
- **One-shot, LSB first.** WIDTH=8, mem[0]=8'hAA, mem[1]=8'hCC, last_word=1, start → 16 valid bits 0,1,0,1,0,1,0,1,0,0,1,1,0,0,1,1; done pulse coincident with the 16th; busy=0 next cycle.
- **MSB first.** Same data, msb_first=1 → 1,0,1,0,1,0,1,0,1,1,0,0,1,1,0,0.
- **Loop with wrap.** mode_loop=1, last_word=0, mem[0]=8'h81 → bits repeat 1,0,0,0,0,0,0,1 every 8 cycles with no gap; done every 8th valid bit.
- **Stall.** stall=1 for 3 cycles after the 4th bit of 8'hAA → 3 out_valid=0 cycles; bit sequence unchanged; done delayed by exactly 3 cycles.
- **Abort and clear mid-frame.**
  - abort at bit 5 → IDLE next edge, no done, counters 0.
  - Repeat with clear pulsed between edges → all outputs 0 immediately; memory still reads 8'hAA afterwards.
- **Start ignored while busy; boundary depth.** start pulsed while busy → no restart. last_word=DEPTH-1 with mem[15]=8'hFF → final 8 bits are all 1, and word_idx wraps to 0.
